// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse keying path.
//   - 2-bit symbol codes (also consumed by the Morse decoder)
//   - unit counts for marks and gaps
//   - ASCII code of the word-gap character
//   - transmitter FSM state encoding
//   - helpers to pick a symbol out of a packed {b0,b1,b2,b3} pattern
package morse_pkg;

  localparam logic [1:0] SYM_GAP  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b11;

  localparam logic [2:0] DOT_UNITS        = 3'd1;
  localparam logic [2:0] DASH_UNITS       = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS    = 3'd1;
  localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;

  localparam logic [7:0] ASCII_SPACE = 8'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_LGAP,
    ST_WGAP
  } state_t;

  // Symbol idx of a packed pattern; idx 0 sits in bits [7:6].
  function automatic logic [1:0] sym_at(input logic [7:0] code, input logic [1:0] idx);
    logic [7:0] sh;
    sh = code << {idx, 1'b0};
    return sh[7:6];
  endfunction

  function automatic logic [2:0] mark_units(input logic [1:0] sym);
    return (sym == SYM_DASH) ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_letter_rom.sv
// morse_letter_rom: combinational ASCII -> packed Morse pattern lookup.
//   i_ascii     : ASCII character
//   o_pattern   : packed {b0,b1,b2,b3}, b0 in [7:6]; 0 for space/unsupported
//   o_supported : 1 for 'A'..'Z' and space, 0 otherwise
module morse_letter_rom
  import morse_pkg::*;
(
  input  logic [7:0] i_ascii,
  output logic [7:0] o_pattern,
  output logic       o_supported
);

  always_comb begin
    o_pattern   = 8'h00;
    o_supported = 1'b1;
    case (i_ascii)
      ASCII_SPACE: o_pattern = 8'h00;
      8'd65: o_pattern = 8'h70; // A .-
      8'd66: o_pattern = 8'hD5; // B -...
      8'd67: o_pattern = 8'hDD; // C -.-.
      8'd68: o_pattern = 8'hD4; // D -..
      8'd69: o_pattern = 8'h40; // E .
      8'd70: o_pattern = 8'h5D; // F ..-.
      8'd71: o_pattern = 8'hF4; // G --.
      8'd72: o_pattern = 8'h55; // H ....
      8'd73: o_pattern = 8'h50; // I ..
      8'd74: o_pattern = 8'h7F; // J .---
      8'd75: o_pattern = 8'hDC; // K -.-
      8'd76: o_pattern = 8'h75; // L .-..
      8'd77: o_pattern = 8'hF0; // M --
      8'd78: o_pattern = 8'hD0; // N -.
      8'd79: o_pattern = 8'hFC; // O ---
      8'd80: o_pattern = 8'h7D; // P .--.
      8'd81: o_pattern = 8'hF7; // Q --.-
      8'd82: o_pattern = 8'h74; // R .-.
      8'd83: o_pattern = 8'h54; // S ...
      8'd84: o_pattern = 8'hC0; // T -
      8'd85: o_pattern = 8'h5C; // U ..-
      8'd86: o_pattern = 8'h57; // V ...-
      8'd87: o_pattern = 8'h7C; // W .--
      8'd88: o_pattern = 8'hD7; // X -..-
      8'd89: o_pattern = 8'hDF; // Y -.--
      8'd90: o_pattern = 8'hF5; // Z --..
      default: o_supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_key_tx.sv
// morse_key_tx: accepts one ASCII character per valid/ready handshake and
// keys it on a single line with standard Morse unit timing.
//   UNIT_CYCLES : clock cycles per Morse unit (>= 1)
//   clk, rst_n  : clock, asynchronous active-low reset
//   ASCIIInput  : character to send;  InValid : character valid
//   InReady     : character can be accepted this cycle
//   KeyOut      : registered key line (1 = mark)
//   Busy        : FSM not in IDLE
//   MorseCode   : pattern latched at accept (0 for space/unsupported)
//   Error       : one-cycle pulse after accepting an unsupported character
module morse_key_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ASCIIInput,
  input  logic       InValid,
  output logic       InReady,
  output logic       KeyOut,
  output logic       Busy,
  output logic [7:0] MorseCode,
  output logic       Error
);

  localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CYC_W-1:0] r_cyc;
  logic [2:0]       r_units;
  logic [1:0]       r_idx;
  logic             r_key;
  logic             r_err;
  logic [7:0]       r_code;

  logic [7:0]       w_rom_pat;
  logic             w_rom_ok;
  logic             w_tick;
  logic             w_unit_done;
  logic             w_gap_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_enter;
  logic [2:0]       w_units_load;
  logic [1:0]       w_idx_next;
  logic [1:0]       w_nxt_sym;

  morse_letter_rom u_rom (
    .i_ascii     (ASCIIInput),
    .o_pattern   (w_rom_pat),
    .o_supported (w_rom_ok)
  );

  assign w_tick      = (r_cyc == CYC_LAST);
  assign w_unit_done = w_tick && (r_units == 3'd1);
  assign w_gap_last  = ((r_state == ST_LGAP) || (r_state == ST_WGAP)) && w_unit_done;

  // Ready is also raised in the final cycle of a trailing gap, so a held
  // InValid is accepted on the same edge the gap ends and the letter gap
  // stays the only spacing between back-to-back characters.
  assign w_ready  = (r_state == ST_IDLE) || w_gap_last;
  assign w_accept = InValid && w_ready;

  // r_idx is always < 3 when this is consumed, so the wrap is harmless.
  assign w_nxt_sym = sym_at(r_code, 2'(r_idx + 2'd1));

  always_comb begin
    w_state_next = r_state;
    w_enter      = 1'b0;
    w_units_load = 3'd0;
    w_idx_next   = r_idx;

    case (r_state)
      ST_MARK: begin
        if (w_unit_done) begin
          w_enter = 1'b1;
          if ((r_idx != 2'd3) && (w_nxt_sym != SYM_GAP)) begin
            w_state_next = ST_SPACE;
            w_units_load = SYM_GAP_UNITS;
          end else begin
            w_state_next = ST_LGAP;
            w_units_load = LETTER_GAP_UNITS;
          end
        end
      end
      ST_SPACE: begin
        if (w_unit_done) begin
          w_enter      = 1'b1;
          w_state_next = ST_MARK;
          w_idx_next   = 2'(r_idx + 2'd1);
          w_units_load = mark_units(w_nxt_sym);
        end
      end
      ST_LGAP, ST_WGAP: begin
        if (w_unit_done) begin
          w_enter      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: ;
    endcase

    // A new character overrides the gap-end return to IDLE.
    if (w_accept) begin
      w_enter    = 1'b1;
      w_idx_next = 2'd0;
      if (!w_rom_ok) begin
        w_state_next = ST_IDLE;
        w_units_load = 3'd0;
      end else if (ASCIIInput == ASCII_SPACE) begin
        w_state_next = ST_WGAP;
        w_units_load = WORD_GAP_UNITS;
      end else begin
        w_state_next = ST_MARK;
        w_units_load = mark_units(w_rom_pat[7:6]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cyc   <= '0;
      r_units <= 3'd0;
      r_idx   <= 2'd0;
      r_key   <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_key   <= (w_state_next == ST_MARK);
      r_err   <= w_accept && !w_rom_ok;
      if (w_accept) begin
        r_code <= w_rom_pat;
      end
      if (w_enter) begin
        r_cyc   <= '0;
        r_units <= w_units_load;
      end else if (r_state != ST_IDLE) begin
        if (w_tick) begin
          r_cyc   <= '0;
          r_units <= r_units - 3'd1;
        end else begin
          r_cyc <= r_cyc + CYC_W'(1);
        end
      end
    end
  end

  assign InReady   = w_ready;
  assign KeyOut    = r_key;
  assign Busy      = (r_state != ST_IDLE);
  assign MorseCode = r_code;
  assign Error     = r_err;

endmodule

// File: tb/tb_morse_key_tx.sv
module tb_morse_key_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ascii, ascii1;
  logic       valid, valid1;
  logic       ready, key, busy, err;
  logic       ready1, key1, busy1, err1;
  logic [7:0] code, code1;

  int checks = 0;
  int errors = 0;
  bit exp_w[$];

  always #5 clk = ~clk;

  morse_key_tx #(.UNIT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ASCIIInput(ascii), .InValid(valid), .InReady(ready),
    .KeyOut(key), .Busy(busy), .MorseCode(code), .Error(err)
  );

  morse_key_tx #(.UNIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ASCIIInput(ascii1), .InValid(valid1), .InReady(ready1),
    .KeyOut(key1), .Busy(busy1), .MorseCode(code1), .Error(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected key waveform of one letter written as dots/dashes, u cycles per unit.
  function automatic void build_wave(string m, int u);
    for (int i = 0; i < m.len(); i++) begin
      int n;
      n = (m[i] == "-") ? 3 : 1;
      for (int c = 0; c < n * u; c++) exp_w.push_back(1'b1);
      if (i < m.len() - 1)
        for (int c = 0; c < u; c++) exp_w.push_back(1'b0);
    end
    for (int c = 0; c < 3 * u; c++) exp_w.push_back(1'b0);
  endfunction

  function automatic logic [7:0] pat_of(string m);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < m.len(); i++)
      p = p | (((m[i] == "-") ? 8'h03 : 8'h01) << (6 - 2 * i));
    return p;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ascii = 8'h00; valid = 1'b0; ascii1 = 8'h00; valid1 = 1'b0;
    #12;
    checks++; if (key !== 1'b0) begin errors++; $display("FAIL reset_key: got %b want 0", key); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", code); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (ready1 !== 1'b1 || key1 !== 1'b0) begin errors++; $display("FAIL reset_u1: ready %b key %b want 1 0", ready1, key1); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_letter_e();
    ascii = 8'd69; valid = 1'b1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL e_ready_pre: got %b want 1", ready); end
    tick();
    valid = 1'b0;
    exp_w.delete();
    build_wave(".", 4);
    checks++; if (code !== 8'h40) begin errors++; $display("FAIL e_code: got %h want 40", code); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL e_busy: got %b want 1", busy); end
    for (int j = 0; j < exp_w.size(); j++) begin
      checks++; if (key !== exp_w[j]) begin errors++; $display("FAIL e_key[%0d]: got %b want %b", j, key, exp_w[j]); end
      checks++; if (ready !== (j == 15)) begin errors++; $display("FAIL e_ready[%0d]: got %b want %b", j, ready, (j == 15)); end
      tick();
    end
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || key !== 1'b0) begin errors++; $display("FAIL e_end: busy %b ready %b key %b want 0 1 0", busy, ready, key); end
  endtask

  task automatic test_back_to_back();
    int lo;
    exp_w.delete();
    build_wave("---", 4);
    lo = exp_w.size();
    build_wave(".-", 4);
    ascii = 8'd79; valid = 1'b1;
    tick();
    ascii = 8'd65;
    for (int j = 0; j < exp_w.size(); j++) begin
      if (j == 0) begin
        checks++; if (code !== 8'hFC) begin errors++; $display("FAIL oa_code_o: got %h want fc", code); end
      end
      if (j == lo) begin
        checks++; if (code !== 8'h70) begin errors++; $display("FAIL oa_code_a: got %h want 70", code); end
        valid = 1'b0;
      end
      checks++; if (key !== exp_w[j]) begin errors++; $display("FAIL oa_key[%0d]: got %b want %b", j, key, exp_w[j]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oa_busy[%0d]: got %b want 1", j, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0 || key !== 1'b0) begin errors++; $display("FAIL oa_end: busy %b key %b want 0 0", busy, key); end
  endtask

  task automatic test_invalid();
    ascii = 8'd35; valid = 1'b1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL inv_ready_pre: got %b want 1", ready); end
    tick();
    ascii = 8'd84;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL inv_err: got %b want 1", err); end
    checks++; if (key !== 1'b0) begin errors++; $display("FAIL inv_key: got %b want 0", key); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL inv_ready: got %b want 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy: got %b want 0", busy); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL inv_code: got %h want 00", code); end
    tick();
    valid = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL inv_err_pulse: got %b want 0", err); end
    checks++; if (code !== 8'hC0) begin errors++; $display("FAIL inv_t_code: got %h want c0", code); end
    exp_w.delete();
    build_wave("-", 4);
    for (int j = 0; j < exp_w.size(); j++) begin
      checks++; if (key !== exp_w[j]) begin errors++; $display("FAIL inv_t_key[%0d]: got %b want %b", j, key, exp_w[j]); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_t_end: busy %b want 0", busy); end
  endtask

  task automatic test_space();
    ascii = 8'd32; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL sp_code: got %h want 00", code); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sp_err: got %b want 0", err); end
    for (int j = 0; j < 28; j++) begin
      checks++; if (key !== 1'b0) begin errors++; $display("FAIL sp_key[%0d]: got %b want 0", j, key); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sp_busy[%0d]: got %b want 1", j, busy); end
      tick();
    end
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL sp_end: busy %b ready %b want 0 1", busy, ready); end
  endtask

  task automatic test_reset_mid();
    ascii = 8'd81; valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++; if (key !== 1'b1) begin errors++; $display("FAIL q_key: got %b want 1", key); end
    checks++; if (code !== 8'hF7) begin errors++; $display("FAIL q_code: got %h want f7", code); end
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (key !== 1'b0) begin errors++; $display("FAIL q_rst_key: got %b want 0", key); end
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL q_rst_state: ready %b busy %b want 1 0", ready, busy); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL q_rst_code: got %h want 00", code); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (key !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL q_after: key %b ready %b busy %b want 0 1 0", key, ready, busy); end
    ascii = 8'd84; valid = 1'b1;
    tick();
    valid = 1'b0;
    exp_w.delete();
    build_wave("-", 4);
    for (int j = 0; j < exp_w.size(); j++) begin
      checks++; if (key !== exp_w[j]) begin errors++; $display("FAIL q_t_key[%0d]: got %b want %b", j, key, exp_w[j]); end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL q_t_end: busy %b want 0", busy); end
  endtask

  task automatic test_all_letters_u1();
    string morse [26];
    morse = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
              "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
              "..-", "...-", ".--", "-..-", "-.--", "--.."};
    ascii1 = 8'd65; valid1 = 1'b1;
    tick();
    for (int li = 0; li < 26; li++) begin
      int len;
      exp_w.delete();
      build_wave(morse[li], 1);
      len = exp_w.size();
      if (li < 25) ascii1 = 8'(66 + li);
      else valid1 = 1'b0;
      checks++; if (code1 !== pat_of(morse[li])) begin errors++; $display("FAIL u1_code[%0d]: got %h want %h", li, code1, pat_of(morse[li])); end
      for (int j = 0; j < len; j++) begin
        checks++; if (key1 !== exp_w[j]) begin errors++; $display("FAIL u1_key[%0d][%0d]: got %b want %b", li, j, key1, exp_w[j]); end
        checks++; if (ready1 !== (j == len - 1)) begin errors++; $display("FAIL u1_ready[%0d][%0d]: got %b want %b", li, j, ready1, (j == len - 1)); end
        tick();
      end
    end
    checks++; if (busy1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL u1_end: busy %b err %b want 0 0", busy1, err1); end
  endtask

  initial begin
    test_reset();
    test_letter_e();
    test_back_to_back();
    test_invalid();
    test_space();
    test_reset_mid();
    test_all_letters_u1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
